// File: rtl/tc_pwr_domain_ctrl.sv
// Power-domain sequencer: switch-chain enable, isolation enable and output clamp for one gated domain.
// Optional acknowledge-timeout detection is enabled by defining TC_PWR_ACK_TIMEOUT_EN.
module tc_pwr_domain_ctrl #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] CLAMP_VAL     = '0,
  parameter int unsigned           SETTLE_CYCLES = 4,
  parameter int                    ISO_CYCLES    = 2,
  parameter int unsigned           ACK_TIMEOUT   = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pwr_on_req_i,
  output logic                  pwr_on_ack_o,
  output logic                  busy_o,
  output logic                  sleep_o,
  input  logic                  sleepout_i,
  output logic                  iso_en_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  err_o
);

  localparam int ISO_EFF = (ISO_CYCLES < 1) ? 1 : ISO_CYCLES;
  localparam int SCW     = $clog2((SETTLE_CYCLES > 2) ? SETTLE_CYCLES : 2) + 1;
  localparam int ICW     = $clog2((ISO_EFF > 2) ? ISO_EFF : 2) + 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_PWR_UP,
    S_SETTLE,
    S_ON,
    S_ISO_HOLD,
    S_PWR_DN
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             sleepout_s1;
  logic             sleepout_s2;
  logic [SCW-1:0]   settle_cnt;
  logic [ICW-1:0]   iso_cnt;

  // Synchroniser resets to 1 so an open chain is assumed until proven closed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sleepout_s1 <= 1'b1;
      sleepout_s2 <= 1'b1;
    end else begin
      sleepout_s1 <= sleepout_i;
      sleepout_s2 <= sleepout_s1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_OFF;
    else       state <= next_state;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      settle_cnt <= '0;
      iso_cnt    <= '0;
    end else begin
      if (state != S_SETTLE && next_state == S_SETTLE) settle_cnt <= SCW'(SETTLE_CYCLES);
      else if (state == S_SETTLE)                      settle_cnt <= settle_cnt - 1'b1;

      if (state != S_ISO_HOLD && next_state == S_ISO_HOLD) iso_cnt <= ICW'(ISO_EFF);
      else if (state == S_ISO_HOLD)                        iso_cnt <= iso_cnt - 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    sleep_o      = 1'b1;
    iso_en_o     = 1'b1;
    pwr_on_ack_o = 1'b0;
    busy_o       = 1'b0;
    case (state)
      S_OFF: begin
        if (pwr_on_req_i) next_state = S_PWR_UP;
      end
      S_PWR_UP: begin
        sleep_o = 1'b0;
        busy_o  = 1'b1;
        if (!sleepout_s2) next_state = (SETTLE_CYCLES == 0) ? S_ON : S_SETTLE;
      end
      S_SETTLE: begin
        sleep_o = 1'b0;
        busy_o  = 1'b1;
        if (settle_cnt <= SCW'(1)) next_state = S_ON;
      end
      S_ON: begin
        sleep_o      = 1'b0;
        iso_en_o     = 1'b0;
        pwr_on_ack_o = 1'b1;
        if (!pwr_on_req_i) next_state = S_ISO_HOLD;
      end
      S_ISO_HOLD: begin
        sleep_o = 1'b0;
        busy_o  = 1'b1;
        if (iso_cnt <= ICW'(1)) next_state = S_PWR_DN;
      end
      S_PWR_DN: begin
        busy_o = 1'b1;
        if (sleepout_s2) next_state = S_OFF;
      end
      default: next_state = S_OFF;
    endcase
  end

  assign data_o = iso_en_o ? CLAMP_VAL : data_i;

`ifdef TC_PWR_ACK_TIMEOUT_EN
  localparam int unsigned ATO = (ACK_TIMEOUT == 0) ? 32'd1 : ACK_TIMEOUT;
  localparam int          TW  = $clog2((ATO > 2) ? ATO : 2) + 1;

  logic [TW-1:0] to_cnt;
  logic          err_q;
  logic          waiting;

  assign waiting = (state == S_PWR_UP) || (state == S_PWR_DN);

  // Counts cycles already spent waiting; the flag sets at the end of the ATO-th such cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (next_state != state)                     to_cnt <= '0;
      else if (waiting && to_cnt != TW'(ATO))      to_cnt <= to_cnt + 1'b1;
      if (waiting && next_state == state && to_cnt == TW'(ATO - 1)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tc_pwr_domain_ctrl.sv
// Bench for tc_pwr_domain_ctrl: two instances (settle/iso 4/2 and 0/0) checked every cycle against a phase model.
module tb_tc_pwr_domain_ctrl;

  localparam logic [31:0] CLAMP_A = 32'hFFFF0000;
  localparam logic [31:0] CLAMP_B = 32'h0000FFFF;
  localparam int          TO      = 16;
  localparam int          SETTLE_A = 4, ISO_A = 2;
  localparam int          SETTLE_B = 0, ISO_B = 0;
  localparam int          ISO_EFF_A = (ISO_A < 1) ? 1 : ISO_A;
  localparam int          ISO_EFF_B = (ISO_B < 1) ? 1 : ISO_B;
`ifdef TC_PWR_ACK_TIMEOUT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int PH_OFF = 0, PH_UP = 1, PH_SETTLE = 2, PH_ON = 3, PH_ISO = 4, PH_DN = 5;

  typedef struct {
    int phase;
    int left;
    int waited;
    bit err;
    bit q0;   // chain output sampled at the previous edge
    bit q1;   // chain output sampled two edges ago
  } mdl_t;

  logic        clk = 1'b0, rst = 1'b0, req = 1'b0, stuck = 1'b0, cmp_en = 1'b0;
  logic [31:0] data_in = 32'hDEADBEEF;
  logic        sleep_a, so_a, iso_a, ack_a, busy_a, err_a;
  logic        sleep_b, so_b, iso_b, ack_b, busy_b, err_b;
  logic [31:0] dout_a, dout_b;
  logic [1:0]  chain_a, chain_b;
  logic        prev_sleep_a = 1'b1, prev_iso_a = 1'b1, prev_sleep_b = 1'b1, prev_iso_b = 1'b1;
  mdl_t        mdl_a, mdl_b;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  tc_pwr_domain_ctrl #(.DATA_WIDTH(32), .CLAMP_VAL(CLAMP_A), .SETTLE_CYCLES(SETTLE_A),
                       .ISO_CYCLES(ISO_A), .ACK_TIMEOUT(TO)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .pwr_on_req_i(req), .pwr_on_ack_o(ack_a), .busy_o(busy_a),
    .sleep_o(sleep_a), .sleepout_i(so_a), .iso_en_o(iso_a), .data_i(data_in), .data_o(dout_a),
    .err_o(err_a));

  tc_pwr_domain_ctrl #(.DATA_WIDTH(32), .CLAMP_VAL(CLAMP_B), .SETTLE_CYCLES(SETTLE_B),
                       .ISO_CYCLES(ISO_B), .ACK_TIMEOUT(TO)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .pwr_on_req_i(req), .pwr_on_ack_o(ack_b), .busy_o(busy_b),
    .sleep_o(sleep_b), .sleepout_i(so_b), .iso_en_o(iso_b), .data_i(data_in), .data_o(dout_b),
    .err_o(err_b));

  // Switch chain: the first synchroniser flop sees a change 3 edges after sleep_o changed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_a <= 2'b11;
      chain_b <= 2'b11;
    end else begin
      chain_a <= {chain_a[0], sleep_a};
      chain_b <= {chain_b[0], sleep_b};
    end
  end
  assign so_a = stuck | chain_a[1];
  assign so_b = stuck | chain_b[1];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.phase = PH_OFF; r.left = 0; r.waited = 0; r.err = 1'b0; r.q0 = 1'b1; r.q1 = 1'b1;
    return r;
  endfunction

  // One clock edge of the sequencing rules; the chain state acted on is the one sampled two edges back.
  function automatic mdl_t step(input mdl_t m, input bit req_s, input bit so_s,
                                input int settle, input int iso_eff);
    mdl_t r = m;
    bit   open_seen = m.q1;
    r.q1 = m.q0;
    r.q0 = so_s;
    case (m.phase)
      PH_OFF: if (req_s) begin r.phase = PH_UP; r.waited = 0; end
      PH_UP: begin
        if (!open_seen) begin
          if (settle == 0) r.phase = PH_ON;
          else begin r.phase = PH_SETTLE; r.left = settle; end
        end else begin
          r.waited = m.waited + 1;
          if (ERR_EN && r.waited == TO) r.err = 1'b1;
        end
      end
      PH_SETTLE: begin
        r.left = m.left - 1;
        if (r.left == 0) r.phase = PH_ON;
      end
      PH_ON: if (!req_s) begin r.phase = PH_ISO; r.left = iso_eff; end
      PH_ISO: begin
        r.left = m.left - 1;
        if (r.left == 0) begin r.phase = PH_DN; r.waited = 0; end
      end
      PH_DN: begin
        if (open_seen) r.phase = PH_OFF;
        else begin
          r.waited = m.waited + 1;
          if (ERR_EN && r.waited == TO) r.err = 1'b1;
        end
      end
      default: r.phase = PH_OFF;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_a <= mdl_reset();
      mdl_b <= mdl_reset();
    end else begin
      mdl_a <= step(mdl_a, req, so_a, SETTLE_A, ISO_EFF_A);
      mdl_b <= step(mdl_b, req, so_b, SETTLE_B, ISO_EFF_B);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input mdl_t m, input logic sl, input logic iso,
                           input logic ack, input logic busy, input logic err,
                           input logic [31:0] dout, input logic [31:0] clamp);
    bit e_sleep = (m.phase == PH_OFF) || (m.phase == PH_DN);
    bit e_iso   = (m.phase != PH_ON);
    bit e_ack   = (m.phase == PH_ON);
    bit e_busy  = (m.phase != PH_ON) && (m.phase != PH_OFF);
    chk({tag, ".sleep"}, 32'(sl),   32'(e_sleep));
    chk({tag, ".iso"},   32'(iso),  32'(e_iso));
    chk({tag, ".ack"},   32'(ack),  32'(e_ack));
    chk({tag, ".busy"},  32'(busy), 32'(e_busy));
    chk({tag, ".err"},   32'(err),  32'(m.err));
    chk({tag, ".data"},  dout, e_iso ? clamp : data_in);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_dut("a", mdl_a, sleep_a, iso_a, ack_a, busy_a, err_a, dout_a, CLAMP_A);
      check_dut("b", mdl_b, sleep_b, iso_b, ack_b, busy_b, err_b, dout_b, CLAMP_B);
      if (ack_a) chk("a.ack_safe", 32'({iso_a, sleep_a}), 32'd0);
      if (ack_b) chk("b.ack_safe", 32'({iso_b, sleep_b}), 32'd0);
      if (sleep_a && !prev_sleep_a) chk("a.iso_first", 32'(prev_iso_a), 32'd1);
      if (sleep_b && !prev_sleep_b) chk("b.iso_first", 32'(prev_iso_b), 32'd1);
    end
    prev_sleep_a <= sleep_a;
    prev_iso_a   <= iso_a;
    prev_sleep_b <= sleep_b;
    prev_iso_b   <= iso_b;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb;
    bit bad;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("a.rst_sleep", 32'(sleep_a), 32'd1);
    chk("a.rst_iso",   32'(iso_a),   32'd1);
    chk("a.rst_ack",   32'(ack_a),   32'd0);
    chk("a.rst_busy",  32'(busy_a),  32'd0);
    chk("a.rst_err",   32'(err_a),   32'd0);
    chk("a.rst_clamp", dout_a, 32'hFFFF0000);
    chk("b.rst_clamp", dout_b, 32'h0000FFFF);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    // Power-up: A = 1 + 5 + 4 edges, B = 1 + 5 + 0 edges
    req = 1'b1;
    tick(1);
    n = 1;
    chk("a.sleep_falls", 32'(sleep_a), 32'd0);
    chk("a.iso_held",    32'(iso_a),   32'd1);
    nb = 0;
    while (!ack_a && n < 40) begin
      tick(1);
      n++;
      if (ack_b && nb == 0) nb = n;
    end
    chk("a.up_latency", 32'(n),  32'd10);
    chk("b.up_latency", 32'(nb), 32'd6);
    chk("a.data_pass",  dout_a, 32'hDEADBEEF);
    tick(2);

    // Power-down: iso first, sleep two cycles later, OFF after 1 + 2 + 5 edges
    req = 1'b0;
    tick(1);
    chk("a.iso_rise",     32'(iso_a),   32'd1);
    chk("a.sleep_hold",   32'(sleep_a), 32'd0);
    chk("b.iso_rise",     32'(iso_b),   32'd1);
    tick(1);
    chk("a.sleep_wait",   32'(sleep_a), 32'd0);
    chk("b.sleep_rise",   32'(sleep_b), 32'd1);
    tick(1);
    chk("a.sleep_rise",   32'(sleep_a), 32'd1);
    data_in = 32'h12345678;
    #1 chk("a.clamp_iso", dout_a, 32'hFFFF0000);
    n = 3;
    bad = 1'b0;
    while (busy_a && n < 40) begin
      tick(1);
      n++;
      if (!iso_a) bad = 1'b1;
    end
    chk("a.dn_latency",  32'(n),   32'd8);
    chk("a.iso_no_drop", 32'(bad), 32'd0);
    tick(3);

    // Request dropped for one cycle inside SETTLE: no abort, ON at edge 10
    req = 1'b1;
    tick(7);
    req = 1'b0;
    tick(1);
    req = 1'b1;
    tick(1);
    chk("a.pulse_pre", 32'(ack_a), 32'd0);
    tick(1);
    chk("a.pulse_ack", 32'(ack_a), 32'd1);
    bad = 1'b0;
    repeat (5) begin
      tick(1);
      if (!ack_a || busy_a) bad = 1'b1;
    end
    chk("a.pulse_no_dn", 32'(bad), 32'd0);
    req = 1'b0;
    tick(30);

    // Stuck chain: timeout flag after TO waiting cycles, then late completion
    stuck = 1'b1;
    req = 1'b1;
    tick(16);
    chk("a.err_pre",   32'(err_a), 32'd0);
    tick(1);
    chk("a.err_at_to", 32'(err_a), 32'(ERR_EN));
    chk("b.err_at_to", 32'(err_b), 32'(ERR_EN));
    chk("a.still_wait", 32'({sleep_a, busy_a}), 32'd1);
    stuck = 1'b0;
    n = 0;
    while (!ack_a && n < 40) begin
      tick(1);
      n++;
    end
    chk("a.late_ack",   32'(n),     32'd7);
    chk("a.err_sticky", 32'(err_a), 32'(ERR_EN));
    req = 1'b0;
    tick(30);

    // Reset mid power-up forces the chain open immediately
    req = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    #1;
    chk("a.midrst_sleep", 32'(sleep_a), 32'd1);
    chk("a.midrst_iso",   32'(iso_a),   32'd1);
    chk("a.midrst_busy",  32'(busy_a),  32'd0);
    chk("a.midrst_err",   32'(err_a),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
